// File: rtl/any1_pkg.sv
// Shared types for the any1 core: value and instruction formats, bitfield
// function codes and the reservation-station entry state.
package any1_pkg;

  localparam int VALUE_W = 64;

  typedef logic [VALUE_W-1:0] value_t;

  typedef enum logic [2:0] {
    BF_SET  = 3'd0,
    BF_CLR  = 3'd1,
    BF_CHG  = 3'd2,
    BF_INS  = 3'd3,
    BF_EXT  = 3'd4,
    BF_EXTU = 3'd5,
    BF_FFO  = 3'd6
  } bf_func_e;

  typedef struct packed {
    logic [4:0] opcode;
    bf_func_e   func;
  } instruction_t;

  typedef enum logic [1:0] {
    RSE_FREE = 2'd0,
    RSE_WAIT = 2'd1,
    RSE_RDY  = 2'd2
  } rse_state_e;

endpackage

// File: rtl/any1_bfu_rse.sv
// One bitfield reservation-station entry: captures operands at dispatch,
// snoops the CDB for missing ones and tracks its relative age.
module any1_bfu_rse
  import any1_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int TAGW   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  logic                   issue_i,
  input  logic                   age_i,
  input  logic                   age_clr_i,
  input  instruction_t           inst_i,
  input  logic [TAGW-1:0]        rob_i,
  input  logic [3:0][DWIDTH-1:0] src_val_i,
  input  logic [3:0][TAGW-1:0]   src_tag_i,
  input  logic [3:0]             src_rdy_i,
  input  logic                   cdb_v_i,
  input  logic [TAGW-1:0]        cdb_tag_i,
  input  logic [DWIDTH-1:0]      cdb_val_i,
  output rse_state_e             state_o,
  output logic                   age_o,
  output instruction_t           inst_o,
  output logic [TAGW-1:0]        rob_o,
  output logic [3:0][DWIDTH-1:0] val_o
);

  rse_state_e             state_r;
  logic                   age_r;
  instruction_t           inst_r;
  logic [TAGW-1:0]        rob_r;
  logic [3:0][DWIDTH-1:0] val_r;
  logic [3:0][TAGW-1:0]   tag_r;
  logic [3:0]             have_r;

  logic [3:0]             load_have_s;
  logic [3:0][DWIDTH-1:0] load_val_s;
  logic [3:0]             wake_have_s;
  logic [3:0][DWIDTH-1:0] wake_val_s;

  // Operand presence/value as seen by a dispatch and by a waiting entry this cycle
  always_comb begin
    load_have_s = 4'b0000;
    load_val_s  = '0;
    wake_have_s = 4'b0000;
    wake_val_s  = '0;
    for (int i = 0; i < 4; i++) begin
      load_have_s[i] = src_rdy_i[i] | (cdb_v_i & (cdb_tag_i == src_tag_i[i]));
      if (src_rdy_i[i]) load_val_s[i] = src_val_i[i];
      else              load_val_s[i] = cdb_val_i;
      wake_have_s[i] = have_r[i] | (cdb_v_i & (cdb_tag_i == tag_r[i]));
      if (have_r[i]) wake_val_s[i] = val_r[i];
      else           wake_val_s[i] = cdb_val_i;
    end
  end

  // Entry state: flush beats dispatch, dispatch and issue are mutually exclusive
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= RSE_FREE;
      age_r   <= 1'b0;
      inst_r  <= '0;
      rob_r   <= '0;
      val_r   <= '0;
      tag_r   <= '0;
      have_r  <= 4'b0000;
    end else if (flush_i) begin
      state_r <= RSE_FREE;
      age_r   <= 1'b0;
    end else if (load_i) begin
      state_r <= (&load_have_s) ? RSE_RDY : RSE_WAIT;
      age_r   <= age_i;
      inst_r  <= inst_i;
      rob_r   <= rob_i;
      tag_r   <= src_tag_i;
      have_r  <= load_have_s;
      val_r   <= load_val_s;
    end else if (issue_i) begin
      state_r <= RSE_FREE;
      age_r   <= 1'b0;
    end else begin
      if (age_clr_i) age_r <= 1'b0;
      case (state_r)
        RSE_WAIT: begin
          have_r  <= wake_have_s;
          val_r   <= wake_val_s;
          state_r <= (&wake_have_s) ? RSE_RDY : RSE_WAIT;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_r;
  assign age_o   = age_r;
  assign inst_o  = inst_r;
  assign rob_o   = rob_r;
  assign val_o   = val_r;

endmodule

// File: rtl/any1_bfu_station.sv
// Two-entry reservation station in front of the external bitfield unit, with
// oldest-ready issue and a single held result register.
module any1_bfu_station
  import any1_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int TAGW   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   disp_v_i,
  output logic                   disp_rdy_o,
  input  instruction_t           disp_inst_i,
  input  logic [TAGW-1:0]        disp_rob_i,
  input  logic [3:0][DWIDTH-1:0] src_val_i,
  input  logic [3:0][TAGW-1:0]   src_tag_i,
  input  logic [3:0]             src_rdy_i,
  input  logic                   cdb_v_i,
  input  logic [TAGW-1:0]        cdb_tag_i,
  input  logic [DWIDTH-1:0]      cdb_val_i,
  output instruction_t           bf_inst_o,
  output logic [DWIDTH-1:0]      bf_a_o,
  output logic [DWIDTH-1:0]      bf_b_o,
  output logic [DWIDTH-1:0]      bf_c_o,
  output logic [DWIDTH-1:0]      bf_d_o,
  input  logic [DWIDTH-1:0]      bf_o_i,
  output logic                   res_v_o,
  output logic [TAGW-1:0]        res_tag_o,
  output logic [DWIDTH-1:0]      res_val_o,
  input  logic                   res_ack_i
);

  rse_state_e             state_s [2];
  logic                   age_s   [2];
  instruction_t           inst_s  [2];
  logic [TAGW-1:0]        rob_s   [2];
  logic [3:0][DWIDTH-1:0] val_s   [2];

  logic [1:0] free_s, rdy_s, load_s, issue_s, age_in_s;
  logic       disp_fire_s, sel_s, fire_s;

  logic              res_v_r;
  logic [TAGW-1:0]   res_tag_r;
  logic [DWIDTH-1:0] res_val_r;

  // Dispatch slot choice and oldest-ready issue selection (age bit 1 = younger)
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      free_s[i] = (state_s[i] == RSE_FREE);
      rdy_s[i]  = (state_s[i] == RSE_RDY);
    end
    disp_fire_s = disp_v_i & (|free_s);
    load_s[0]   = disp_fire_s & free_s[0];
    load_s[1]   = disp_fire_s & ~free_s[0] & free_s[1];
    sel_s       = rdy_s[1] & (~rdy_s[0] | age_s[0]);
    fire_s      = (|rdy_s) & (~res_v_r | res_ack_i);
    issue_s[0]  = fire_s & ~sel_s;
    issue_s[1]  = fire_s & sel_s;
    age_in_s[0] = ~free_s[1] & ~issue_s[1];
    age_in_s[1] = ~free_s[0] & ~issue_s[0];
  end

  for (genvar g = 0; g < 2; g++) begin : g_rse
    any1_bfu_rse #(.DWIDTH(DWIDTH), .TAGW(TAGW)) u_rse (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .load_i    (load_s[g]),
      .issue_i   (issue_s[g]),
      .age_i     (age_in_s[g]),
      .age_clr_i (issue_s[1-g]),
      .inst_i    (disp_inst_i),
      .rob_i     (disp_rob_i),
      .src_val_i (src_val_i),
      .src_tag_i (src_tag_i),
      .src_rdy_i (src_rdy_i),
      .cdb_v_i   (cdb_v_i),
      .cdb_tag_i (cdb_tag_i),
      .cdb_val_i (cdb_val_i),
      .state_o   (state_s[g]),
      .age_o     (age_s[g]),
      .inst_o    (inst_s[g]),
      .rob_o     (rob_s[g]),
      .val_o     (val_s[g])
    );
  end

  // Selected entry drives the bitfield unit; idle station drives zeros
  always_comb begin
    bf_inst_o = '0;
    bf_a_o    = '0;
    bf_b_o    = '0;
    bf_c_o    = '0;
    bf_d_o    = '0;
    if (|rdy_s) begin
      bf_inst_o = inst_s[sel_s];
      bf_a_o    = val_s[sel_s][0];
      bf_b_o    = val_s[sel_s][1];
      bf_c_o    = val_s[sel_s][2];
      bf_d_o    = val_s[sel_s][3];
    end else begin
      bf_inst_o = '0;
    end
  end

  // Result register: held until acked, flush drops it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_v_r   <= 1'b0;
      res_tag_r <= '0;
      res_val_r <= '0;
    end else if (flush_i) begin
      res_v_r <= 1'b0;
    end else if (fire_s) begin
      res_v_r   <= 1'b1;
      res_tag_r <= rob_s[sel_s];
      res_val_r <= bf_o_i;
    end else if (res_ack_i) begin
      res_v_r <= 1'b0;
    end
  end

  assign disp_rdy_o = |free_s;
  assign res_v_o    = res_v_r;
  assign res_tag_o  = res_tag_r;
  assign res_val_o  = res_val_r;

endmodule

// File: tb/tb_any1_bfu_station.sv
// Bench for any1_bfu_station: directed scenarios plus a randomized run against
// a sequence-number based station model; the bitfield unit is modelled here.
module tb_any1_bfu_station;
  import any1_pkg::*;

  localparam int DW = 64;
  localparam int TW = 5;

  logic clk_i;
  logic rst_ni, flush_i, disp_v_i, disp_rdy_o, cdb_v_i, res_v_o, res_ack_i;
  instruction_t disp_inst_i, bf_inst_o;
  logic [TW-1:0] disp_rob_i, cdb_tag_i, res_tag_o;
  logic [3:0][DW-1:0] src_val_i;
  logic [3:0][TW-1:0] src_tag_i;
  logic [3:0] src_rdy_i;
  logic [DW-1:0] cdb_val_i, bf_a_o, bf_b_o, bf_c_o, bf_d_o, bf_o_i, res_val_o;

  int errors = 0;
  int checks = 0;

  // model state: entries ordered by dispatch sequence number
  logic         m_valid [2];
  int           m_seq   [2];
  logic [3:0]   m_have  [2];
  logic [63:0]  m_val   [2][4];
  logic [4:0]   m_tag   [2][4];
  instruction_t m_inst  [2];
  logic [4:0]   m_rob   [2];
  logic         m_res_v;
  logic [4:0]   m_res_tag;
  logic [63:0]  m_res_val;
  int           seq_ctr;

  any1_bfu_station #(.DWIDTH(DW), .TAGW(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .disp_v_i(disp_v_i), .disp_rdy_o(disp_rdy_o), .disp_inst_i(disp_inst_i),
    .disp_rob_i(disp_rob_i), .src_val_i(src_val_i), .src_tag_i(src_tag_i),
    .src_rdy_i(src_rdy_i), .cdb_v_i(cdb_v_i), .cdb_tag_i(cdb_tag_i),
    .cdb_val_i(cdb_val_i), .bf_inst_o(bf_inst_o), .bf_a_o(bf_a_o),
    .bf_b_o(bf_b_o), .bf_c_o(bf_c_o), .bf_d_o(bf_d_o), .bf_o_i(bf_o_i),
    .res_v_o(res_v_o), .res_tag_o(res_tag_o), .res_val_o(res_val_o),
    .res_ack_i(res_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // field of width d+1 at offset c
  function automatic logic [63:0] bfu(input instruction_t ins, input logic [63:0] a, b, c, d);
    int off, wid;
    logic [63:0] fmask, mask, r;
    off = int'(c[5:0]);
    wid = int'(d[5:0]) + 1;
    fmask = (wid == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wid) - 64'd1);
    mask = fmask << off;
    case (ins.func)
      BF_SET:  r = a | mask;
      BF_CLR:  r = a & ~mask;
      BF_CHG:  r = a ^ mask;
      BF_INS:  r = (a & ~mask) | ((b << off) & mask);
      BF_EXT:  begin
        r = (a >> off) & fmask;
        if (wid < 64 && r[wid-1]) r = r | ~fmask;
      end
      BF_EXTU: r = (a >> off) & fmask;
      BF_FFO:  begin
        r = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 63; i >= 0; i--) if (mask[i] && a[i]) r = 64'(i);
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  assign bf_o_i = bfu(bf_inst_o, bf_a_o, bf_b_o, bf_c_o, bf_d_o);

  task automatic idle_inputs();
    flush_i = 1'b0; disp_v_i = 1'b0; disp_inst_i = '0; disp_rob_i = '0;
    src_val_i = '0; src_tag_i = '0; src_rdy_i = 4'h0;
    cdb_v_i = 1'b0; cdb_tag_i = '0; cdb_val_i = '0; res_ack_i = 1'b1;
  endtask

  task automatic drive_disp(input bf_func_e f, input logic [4:0] rob,
                            input logic [63:0] a, b, c, d,
                            input logic [3:0] rdy, input logic [4:0] tg);
    disp_v_i = 1'b1;
    disp_inst_i.opcode = 5'h1;
    disp_inst_i.func = f;
    disp_rob_i = rob;
    src_val_i[0] = a; src_val_i[1] = b; src_val_i[2] = c; src_val_i[3] = d;
    src_tag_i = {4{tg}};
    src_rdy_i = rdy;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL reset_res_v: got %0b want 0", res_v_o); end
    checks++; if (res_tag_o !== 5'd0) begin errors++; $display("FAIL reset_res_tag: got %0h want 0", res_tag_o); end
    checks++; if (res_val_o !== 64'd0) begin errors++; $display("FAIL reset_res_val: got %0h want 0", res_val_o); end
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_disp_rdy: got %0b want 1", disp_rdy_o); end
    checks++; if (bf_a_o !== 64'd0) begin errors++; $display("FAIL reset_bf_a: got %0h want 0", bf_a_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_extu();
    do_reset();
    drive_disp(BF_EXTU, 5'd7, 64'hF0, 64'd0, 64'd4, 64'd3, 4'hF, 5'd0);
    @(negedge clk_i);
    idle_inputs();
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL extu_early: got res_v %0b want 0", res_v_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b1) begin errors++; $display("FAIL extu_res_v: got %0b want 1", res_v_o); end
    checks++; if (res_val_o !== 64'h0F) begin errors++; $display("FAIL extu_res_val: got %0h want f", res_val_o); end
    checks++; if (res_tag_o !== 5'd7) begin errors++; $display("FAIL extu_res_tag: got %0d want 7", res_tag_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL extu_ack_clear: got %0b want 0", res_v_o); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    drive_disp(BF_SET, 5'd9, 64'd0, 64'd0, 64'd8, 64'd7, 4'b1101, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle_inputs();
      checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL wake_wait%0d: got res_v %0b want 0", i, res_v_o); end
    end
    @(negedge clk_i);
    cdb_v_i = 1'b1; cdb_tag_i = 5'd3; cdb_val_i = 64'h1234;
    @(negedge clk_i);
    idle_inputs();
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL wake_cdb_edge: got res_v %0b want 0", res_v_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b1) begin errors++; $display("FAIL wake_res_v: got %0b want 1", res_v_o); end
    checks++; if (res_val_o !== 64'hFF00) begin errors++; $display("FAIL wake_res_val: got %0h want ff00", res_val_o); end
    checks++; if (res_tag_o !== 5'd9) begin errors++; $display("FAIL wake_res_tag: got %0d want 9", res_tag_o); end
  endtask

  task automatic test_age_order();
    do_reset();
    drive_disp(BF_EXTU, 5'd10, 64'd0, 64'd0, 64'd0, 64'd63, 4'b1110, 5'd1);
    @(negedge clk_i);
    drive_disp(BF_EXTU, 5'd11, 64'd0, 64'd0, 64'd0, 64'd63, 4'b1110, 5'd2);
    @(negedge clk_i);
    idle_inputs();
    checks++; if (disp_rdy_o !== 1'b0) begin errors++; $display("FAIL age_full_rdy: got %0b want 0", disp_rdy_o); end
    cdb_v_i = 1'b1; cdb_tag_i = 5'd2; cdb_val_i = 64'h2222;
    @(negedge clk_i);
    cdb_tag_i = 5'd1; cdb_val_i = 64'h1111;
    @(negedge clk_i);
    idle_inputs();
    checks++; if (res_v_o !== 1'b1 || res_tag_o !== 5'd11) begin errors++; $display("FAIL age_first: got v=%0b tag=%0d want v=1 tag=11", res_v_o, res_tag_o); end
    checks++; if (res_val_o !== 64'h2222) begin errors++; $display("FAIL age_first_val: got %0h want 2222", res_val_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b1 || res_tag_o !== 5'd10) begin errors++; $display("FAIL age_second: got v=%0b tag=%0d want v=1 tag=10", res_v_o, res_tag_o); end
    checks++; if (res_val_o !== 64'h1111) begin errors++; $display("FAIL age_second_val: got %0h want 1111", res_val_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ack_i = 1'b0;
    drive_disp(BF_EXTU, 5'd1, 64'h111, 64'd0, 64'd0, 64'd63, 4'hF, 5'd0);
    @(negedge clk_i);
    drive_disp(BF_EXTU, 5'd2, 64'h222, 64'd0, 64'd0, 64'd63, 4'hF, 5'd0);
    @(negedge clk_i);
    drive_disp(BF_EXTU, 5'd3, 64'h333, 64'd0, 64'd0, 64'd63, 4'hF, 5'd0);
    @(negedge clk_i);
    idle_inputs();
    res_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_i);
      checks++; if (res_v_o !== 1'b1 || res_tag_o !== 5'd1 || res_val_o !== 64'h111) begin
        errors++; $display("FAIL bp_hold%0d: got v=%0b tag=%0d val=%0h want v=1 tag=1 val=111", i, res_v_o, res_tag_o, res_val_o); end
      checks++; if (disp_rdy_o !== 1'b0) begin errors++; $display("FAIL bp_full%0d: got %0b want 0", i, disp_rdy_o); end
    end
    res_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b1 || res_tag_o !== 5'd2 || res_val_o !== 64'h222) begin
      errors++; $display("FAIL bp_drain1: got v=%0b tag=%0d val=%0h want v=1 tag=2 val=222", res_v_o, res_tag_o, res_val_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b1 || res_tag_o !== 5'd3 || res_val_o !== 64'h333) begin
      errors++; $display("FAIL bp_drain2: got v=%0b tag=%0d val=%0h want v=1 tag=3 val=333", res_v_o, res_tag_o, res_val_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b want 0", res_v_o); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_disp(BF_EXTU, 5'd2, 64'h55, 64'd0, 64'd0, 64'd63, 4'hF, 5'd0);
    @(negedge clk_i);
    checks++; if (bf_a_o !== 64'h55) begin errors++; $display("FAIL flush_pre_sel: got %0h want 55", bf_a_o); end
    drive_disp(BF_EXTU, 5'd3, 64'h66, 64'd0, 64'd0, 64'd63, 4'hF, 5'd0);
    flush_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL flush_res_v: got %0b want 0", res_v_o); end
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL flush_disp_rdy: got %0b want 1", disp_rdy_o); end
    checks++; if (bf_a_o !== 64'd0) begin errors++; $display("FAIL flush_no_entry: got bf_a %0h want 0", bf_a_o); end
    @(negedge clk_i);
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL flush_no_issue: got %0b want 0", res_v_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    res_ack_i = 1'b0;
    drive_disp(BF_EXTU, 5'd4, 64'h77, 64'd0, 64'd0, 64'd63, 4'hF, 5'd0);
    @(negedge clk_i);
    drive_disp(BF_EXTU, 5'd6, 64'h0, 64'd0, 64'd0, 64'd63, 4'b1110, 5'd5);
    @(negedge clk_i);
    idle_inputs();
    res_ack_i = 1'b0;
    checks++; if (res_v_o !== 1'b1 || res_tag_o !== 5'd4) begin errors++; $display("FAIL arst_pre: got v=%0b tag=%0d want v=1 tag=4", res_v_o, res_tag_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (res_v_o !== 1'b0 || res_tag_o !== 5'd0 || res_val_o !== 64'd0) begin
      errors++; $display("FAIL arst_outputs: got v=%0b tag=%0d val=%0h want all 0", res_v_o, res_tag_o, res_val_o); end
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL arst_disp_rdy: got %0b want 1", disp_rdy_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    res_ack_i = 1'b1;
    cdb_v_i = 1'b1; cdb_tag_i = 5'd5; cdb_val_i = 64'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      cdb_v_i = 1'b0;
      checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL arst_discard%0d: got %0b want 0", i, res_v_o); end
    end
  endtask

  // model advances by one clock edge using the inputs currently driven
  task automatic model_step();
    int didx, pick;
    logic fire;
    didx = -1;
    if (disp_v_i) for (int i = 1; i >= 0; i--) if (!m_valid[i]) didx = i;
    pick = -1;
    for (int i = 0; i < 2; i++)
      if (m_valid[i] && m_have[i] == 4'hF && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
    fire = (pick >= 0) && (!m_res_v || res_ack_i);
    if (flush_i) begin
      m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_res_v = 1'b0;
      return;
    end
    if (fire) begin
      m_res_v = 1'b1;
      m_res_tag = m_rob[pick];
      m_res_val = bfu(m_inst[pick], m_val[pick][0], m_val[pick][1], m_val[pick][2], m_val[pick][3]);
      m_valid[pick] = 1'b0;
    end else if (res_ack_i) begin
      m_res_v = 1'b0;
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        if (m_valid[i] && !m_have[i][k] && cdb_v_i && cdb_tag_i == m_tag[i][k]) begin
          m_have[i][k] = 1'b1; m_val[i][k] = cdb_val_i;
        end
    if (didx >= 0) begin
      m_valid[didx] = 1'b1; m_seq[didx] = seq_ctr; seq_ctr++;
      m_inst[didx] = disp_inst_i; m_rob[didx] = disp_rob_i;
      for (int k = 0; k < 4; k++) begin
        m_tag[didx][k] = src_tag_i[k];
        if (src_rdy_i[k]) begin m_have[didx][k] = 1'b1; m_val[didx][k] = src_val_i[k]; end
        else if (cdb_v_i && cdb_tag_i == src_tag_i[k]) begin m_have[didx][k] = 1'b1; m_val[didx][k] = cdb_val_i; end
        else m_have[didx][k] = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_res_v = 1'b0; seq_ctr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      checks++; if (disp_rdy_o !== (!m_valid[0] || !m_valid[1])) begin
        errors++; $display("FAIL rnd_disp_rdy @%0d: got %0b want %0b", cyc, disp_rdy_o, (!m_valid[0] || !m_valid[1])); end
      checks++; if (res_v_o !== m_res_v) begin
        errors++; $display("FAIL rnd_res_v @%0d: got %0b want %0b", cyc, res_v_o, m_res_v); end
      if (m_res_v) begin
        checks++; if (res_tag_o !== m_res_tag || res_val_o !== m_res_val) begin
          errors++; $display("FAIL rnd_result @%0d: got tag=%0d val=%0h want tag=%0d val=%0h", cyc, res_tag_o, res_val_o, m_res_tag, m_res_val); end
      end
      disp_v_i = ($urandom_range(0, 99) < 50);
      disp_inst_i.opcode = 5'($urandom_range(0, 31));
      disp_inst_i.func = bf_func_e'(3'($urandom_range(0, 6)));
      disp_rob_i = 5'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++) begin
        src_val_i[k] = {$urandom, $urandom};
        src_tag_i[k] = 5'($urandom_range(1, 3));
        src_rdy_i[k] = ($urandom_range(0, 3) != 0);
      end
      cdb_v_i = ($urandom_range(0, 99) < 40);
      cdb_tag_i = 5'($urandom_range(0, 3));
      cdb_val_i = {$urandom, $urandom};
      res_ack_i = ($urandom_range(0, 99) < 70);
      flush_i = ($urandom_range(0, 99) < 2);
      model_step();
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_extu();
    test_cdb_wakeup();
    test_age_order();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/any1_bfu_station.md
ANY1_BFU_STATION -- requirements
Module: any1_bfu_station

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, meaning operand/result width in bits.
REQ-002 SHALL have parameter TAGW, default 5, meaning reorder-buffer tag width.
REQ-003 SHALL have a single clock clk_i and an asynchronous, active-low reset rst_ni; no other clock or reset.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- flush_i  in  1  sync pipeline flush.
- disp_v_i  in  1  dispatch valid.
- disp_rdy_o  out  1  a station entry is free.
- disp_inst_i  in  Instruction  bitfield instruction.
- disp_rob_i  in  TAGW  destination tag.
- src_val_i  in  4xValue  operands a,b,c,d.
- src_tag_i  in  4xTAGW  producer tags.
- src_rdy_i  in  4  operand value already present.
- cdb_v_i  in  1  common data bus valid.
- cdb_tag_i  in  TAGW  CDB tag.
- cdb_val_i  in  Value  CDB result.
- bf_inst_o  out  Instruction  to bitfield unit.
- bf_a_o, bf_b_o, bf_c_o, bf_d_o  out  Value  operands to bitfield unit.
- bf_o_i  in  Value  combinational bitfield result.
- res_v_o  out  1  result valid.
- res_tag_o  out  TAGW  result tag.
- res_val_o  out  Value  result.
- res_ack_i  in  1  result consumed.

Function
REQ-005 The station SHALL hold 2 entries; each entry SHALL be in one of the states FREE, WAIT (an operand is missing), or RDY (all 4 operands present).
REQ-006 disp_rdy_o SHALL be 1 when any entry is FREE; a dispatch occurs when disp_v_i && disp_rdy_o, and the lowest-index FREE entry is written.
REQ-007 For each operand with src_rdy_i=0, if cdb_v_i is set and cdb_tag_i equals the operand tag in the dispatch cycle, the SHALL capture cdb_val_i and mark the operand present.
REQ-008 Each WAIT entry SHALL capture cdb_val_i into every missing operand whose tag equals cdb_tag_i when cdb_v_i=1; the entry goes WAIT->RDY on the edge its last operand arrives.
REQ-009 Issue SHALL select the oldest RDY entry (per-entry age bit, set on dispatch relative to the other valid entry) and drive it on bf_*_o; if nothing is selected, bf_*_o SHALL be 0.
REQ-010 Issue SHALL fire when a RDY entry exists and (res_v_o=0 or res_ack_i=1); on that edge bf_o_i and the entry tag load the result register, res_v_o becomes 1, and the entry becomes FREE.
REQ-011 res_v_o, res_tag_o, and res_val_o SHALL hold stable while res_v_o && !res_ack_i; ack without a new issue SHALL clear res_v_o.
REQ-012 Latency: dispatch with all operands ready at edge N SHALL give res_v_o=1 after edge N+1; throughput is 1 result/cycle with continuous ack.
REQ-013 A dispatch, a CDB wakeup, and an issue in the same cycle SHALL all take effect; a freed entry is not re-dispatchable until the next cycle (disp_rdy_o is computed from registered state).
REQ-014 flush_i SHALL set all entries to FREE and clear res_v_o on the next edge, overriding a same-cycle dispatch or issue.

Reset
REQ-015 While rst_ni=0, all entries SHALL be FREE, age bits 0, res_v_o=0, res_tag_o=0, res_val_o=0; disp_rdy_o SHALL therefore be 1.
REQ-016 Reset asserted mid-operation SHALL discard in-flight entries and the result without emitting them.

Structure
REQ-017 The Instruction and Value types and the bitfield func codes (SET=0 .. FFO=6) SHALL come from any1_pkg; the entry state enum SHALL be added to any1_pkg.
REQ-018 The bitfield unit SHALL stay external; a single sub-module any1_bfu_rse (one entry with operand capture and wakeup) SHALL be instantiated twice.

Verification
REQ-019 Dispatch BFEXTU (func=5), a=0xF0, c=4, d=3, all ready -> res_v_o=1 one edge later with res_val_o=0x0F and res_tag_o=disp_rob_i.
REQ-020 Dispatch BFSET, a=0, c=8, d=7, with b unready (tag 3); CDB tag 3 arrives 5 cycles later -> result 0xFF00 on the edge after CDB.
REQ-021 Fill both entries with operands waiting on tags 1 and 2, then broadcast tag 2 before tag 1 -> entry 2 issues first, and disp_rdy_o=0 while both are occupied.
REQ-022 Hold res_ack_i=0 for 4 cycles with 2 RDY entries -> result stays stable, no issue occurs, and both results drain in age order once ack is given.
REQ-023 Assert flush_i in the same cycle as a dispatch and an issue -> next cycle res_v_o=0, disp_rdy_o=1, and no entry is valid.
REQ-024 Pulse rst_ni low mid-wait asynchronously -> outputs are zero before the next clock edge.
